demux_1x4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer with a valid/ready handshake on the input and on each of the four outputs.
- Sits directly downstream of a single-source producer. It routes each accepted word to channel 0..3, selected either by an explicit sel or by an internal round-robin pointer.
- Each channel holds a one-entry output buffer, so a stalled consumer blocks only its own channel.
- It is the clocked, back-pressured successor to the combinational demux_1x4.

---
 rtl/demux_1x4_stream.sv | 82 ++++++++
 tb/tb_demux_1x4_stream.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream
//   Registered 1-to-4 stream demultiplexer. Each accepted input word is routed
//   to one of four channels, chosen by sel or by an internal round-robin
//   pointer. Every channel owns a one-entry output buffer, so a stalled
//   consumer back-pressures only when it is the current target.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   din         input word (WIDTH bits)
//   din_valid   din is presented this cycle
//   din_ready   block accepts din this cycle (combinational)
//   sel         target channel when auto_rr = 0
//   auto_rr     1: target is rr_ptr, 0: target is sel
//   dout_0..3   channel buffer data
//   dout_valid  bit N set while dout_N holds an unconsumed word
//   dout_ready  bit N set when consumer N takes dout_N this cycle
//   rr_ptr      current round-robin pointer
module demux_1x4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [1:0]       sel,
  input  logic             auto_rr,
  output logic [WIDTH-1:0] dout_0,
  output logic [WIDTH-1:0] dout_1,
  output logic [WIDTH-1:0] dout_2,
  output logic [WIDTH-1:0] dout_3,
  output logic [3:0]       dout_valid,
  input  logic [3:0]       dout_ready,
  output logic [1:0]       rr_ptr
);

  logic [WIDTH-1:0] data_p0 [4];
  logic [3:0]       vld_p0;
  logic [1:0]       rr_p0;
  logic [1:0]       tgt;
  logic             accept;

  assign tgt = auto_rr ? rr_p0 : sel;

  // The target buffer can take a word when empty or when it drains this
  // same cycle, which keeps throughput at one word per cycle.
  assign din_ready = rst_n & (~vld_p0[tgt] | dout_ready[tgt]);
  assign accept    = din_valid & din_ready;

  // Stage p0: per-channel one-entry buffers and the round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 4'b0000;
      rr_p0  <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        data_p0[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        // A refill wins over a drain so the slot never bubbles.
        if (accept && (tgt == 2'(n))) begin
          data_p0[n] <= din;
          vld_p0[n]  <= 1'b1;
        end else if (vld_p0[n] && dout_ready[n]) begin
          vld_p0[n]  <= 1'b0;
        end
      end
      if (accept && auto_rr) begin
        rr_p0 <= rr_p0 + 2'd1;
      end
    end
  end

  assign dout_0     = data_p0[0];
  assign dout_1     = data_p0[1];
  assign dout_2     = data_p0[2];
  assign dout_3     = data_p0[3];
  assign dout_valid = vld_p0;
  assign rr_ptr     = rr_p0;

endmodule

// File: tb/tb_demux_1x4_stream.sv
module tb_demux_1x4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] sel;
  logic       auto_rr;
  logic [7:0] dout_0, dout_1, dout_2, dout_3;
  logic [3:0] dout_valid;
  logic [3:0] dout_ready;
  logic [1:0] rr_ptr;

  logic [7:0] dout_arr [4];
  logic [7:0] sb [4][$];
  logic [1:0] m_rr;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  assign dout_arr[0] = dout_0;
  assign dout_arr[1] = dout_1;
  assign dout_arr[2] = dout_2;
  assign dout_arr[3] = dout_3;

  always #5 clk = ~clk;

  demux_1x4_stream #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sel        (sel),
    .auto_rr    (auto_rr),
    .dout_0     (dout_0),
    .dout_1     (dout_1),
    .dout_2     (dout_2),
    .dout_3     (dout_3),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rr_ptr     (rr_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, check din_ready and any output transfers
  // before the edge, then check dout_valid and rr_ptr after the edge.
  task automatic step(input logic [7:0] d, input logic v, input logic [1:0] s,
                      input logic a, input logic [3:0] rdy, input logic exp_rdy,
                      input logic [3:0] exp_dv, input logic [1:0] exp_rr);
    logic [1:0] t;
    @(negedge clk);
    din = d; din_valid = v; sel = s; auto_rr = a; dout_ready = rdy;
    #1;
    chk("din_ready", din_ready, exp_rdy);
    for (int n = 0; n < 4; n++) begin
      if (dout_valid[n] && dout_ready[n]) begin
        if (sb[n].size() == 0) chk($sformatf("ch%0d_extra_word", n), dout_valid[n], 1'b0);
        else chk($sformatf("ch%0d_data", n), dout_arr[n], sb[n].pop_front());
      end
    end
    if (v && exp_rdy) begin
      t = a ? m_rr : s;
      sb[t].push_back(d);
      if (a) m_rr = m_rr + 2'd1;
    end
    @(posedge clk);
    #1;
    chk("dout_valid", dout_valid, exp_dv);
    chk("rr_ptr", rr_ptr, exp_rr);
  endtask

  initial begin
    m_rr = 2'd0;
    rst_n = 1'b0; din = 8'hFF; din_valid = 1'b1; sel = 2'd1; auto_rr = 1'b0;
    dout_ready = 4'b1111;

    // reset for two edges with din_valid high
    @(negedge clk); #1;
    chk("rst_din_ready", din_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_dout_valid", dout_valid, 4'b0000);
    chk("rst_rr_ptr", rr_ptr, 2'd0);
    chk("rst_dout_0", dout_0, 8'h00);
    chk("rst_dout_1", dout_1, 8'h00);
    chk("rst_dout_2", dout_2, 8'h00);
    chk("rst_dout_3", dout_3, 8'h00);
    @(negedge clk); rst_n = 1'b1; din_valid = 1'b0;

    // sel steering
    step(8'hA0, 1, 2'd0, 0, 4'b1111, 1, 4'b0001, 2'd0);
    step(8'hA1, 1, 2'd1, 0, 4'b1111, 1, 4'b0010, 2'd0);
    step(8'hA2, 1, 2'd2, 0, 4'b1111, 1, 4'b0100, 2'd0);
    step(8'hA3, 1, 2'd3, 0, 4'b1111, 1, 4'b1000, 2'd0);

    // back-pressure on channel 2
    step(8'h55, 1, 2'd2, 0, 4'b1011, 1, 4'b0100, 2'd0);
    step(8'h66, 1, 2'd2, 0, 4'b1011, 0, 4'b0100, 2'd0);
    chk("bp_hold_dout_2", dout_2, 8'h55);
    step(8'h66, 1, 2'd2, 0, 4'b1111, 1, 4'b0100, 2'd0);
    chk("bp_refill_dout_2", dout_2, 8'h66);

    // round-robin with wrap
    step(8'h10, 1, 2'd3, 1, 4'b1111, 1, 4'b0001, 2'd1);
    step(8'h11, 1, 2'd3, 1, 4'b1111, 1, 4'b0010, 2'd2);
    step(8'h12, 1, 2'd3, 1, 4'b1111, 1, 4'b0100, 2'd3);
    step(8'h13, 1, 2'd3, 1, 4'b1111, 1, 4'b1000, 2'd0);
    step(8'h14, 1, 2'd3, 1, 4'b1111, 1, 4'b0001, 2'd1);
    step(8'h15, 1, 2'd3, 1, 4'b1111, 1, 4'b0010, 2'd2);

    // walk pointer back to 1 while channel 1 stays full
    step(8'h16, 1, 2'd0, 1, 4'b1101, 1, 4'b0110, 2'd3);
    step(8'h17, 1, 2'd0, 1, 4'b1101, 1, 4'b1010, 2'd0);
    step(8'h18, 1, 2'd0, 1, 4'b1101, 1, 4'b0011, 2'd1);
    // RR stall: pointer must not skip the full channel
    step(8'h19, 1, 2'd0, 1, 4'b1101, 0, 4'b0010, 2'd1);
    step(8'h19, 1, 2'd0, 1, 4'b1101, 0, 4'b0010, 2'd1);
    // explicit sel bypasses the stall without moving the pointer
    step(8'h19, 1, 2'd3, 0, 4'b1101, 1, 4'b1010, 2'd1);
    chk("stall_dout_1", dout_1, 8'h15);
    chk("sel_dout_3", dout_3, 8'h19);
    step(8'h20, 1, 2'd0, 0, 4'b0000, 1, 4'b1011, 2'd1);

    // reset mid-operation discards buffered words
    @(negedge clk);
    rst_n = 1'b0; din = 8'h77; din_valid = 1'b1; auto_rr = 1'b1;
    for (int n = 0; n < 4; n++) sb[n].delete();
    m_rr = 2'd0;
    #1;
    chk("mid_rst_din_ready", din_ready, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_dout_valid", dout_valid, 4'b0000);
    chk("mid_rst_rr_ptr", rr_ptr, 2'd0);
    @(negedge clk); rst_n = 1'b1; din_valid = 1'b0;

    step(8'h30, 1, 2'd2, 1, 4'b1111, 1, 4'b0001, 2'd1);
    chk("post_rst_dout_0", dout_0, 8'h30);
    step(8'h00, 0, 2'd2, 1, 4'b1111, 1, 4'b0000, 2'd1);

    for (int n = 0; n < 4; n++) chk($sformatf("ch%0d_leftover", n), sb[n].size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
